// File: rtl/alu64_fpu_unit.sv
// alu64_fpu_unit -- execute-stage arithmetic block.
//   64-bit RV64-style integer ALU plus binary32 FP add/sub/mul, both results
//   registered with one-cycle latency under a shared issue strobe.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears outputs)
//   op_a, op_b, opcode  integer operands / op select (0..9, others give 0)
//   fop_a, fop_b        binary32 operands
//   fopcode             FP op select (0 FADD, 1 FSUB, 2 FMUL, others give 0)
//   valid               issue strobe; when low both outputs hold
//   result, fresult     registered integer / FP results
module alu64_fpu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic [3:0]  opcode,
    input  logic        valid,
    output logic [63:0] result,
    input  logic [31:0] fop_a,
    input  logic [31:0] fop_b,
    input  logic [2:0]  fopcode,
    output logic [31:0] fresult
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- integer ALU ----------------
    logic [63:0] int_res;

    always_comb begin
        int_res = '0;
        case (opcode)
            4'h0: int_res = op_a + op_b;
            4'h1: int_res = op_a - op_b;
            4'h2: int_res = op_a & op_b;
            4'h3: int_res = op_a | op_b;
            4'h4: int_res = op_a ^ op_b;
            4'h5: int_res = op_a << op_b[5:0];
            4'h6: int_res = op_a >> op_b[5:0];
            4'h7: int_res = $signed(op_a) >>> op_b[5:0];
            4'h8: int_res = {63'b0, $signed(op_a) < $signed(op_b)};
            4'h9: int_res = {63'b0, op_a < op_b};
            default: int_res = '0;
        endcase
    end

    // ---------------- FP operand classification ----------------
    logic        sa, sb, sb_add, sm;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa     = fop_a[31];
    assign sb     = fop_b[31];
    assign ea     = fop_a[30:23];
    assign eb     = fop_b[30:23];
    assign ma     = fop_a[22:0];
    assign mb     = fop_b[22:0];
    assign sb_add = sb ^ (fopcode == 3'd1);   // FSUB is FADD with b negated
    assign sm     = sa ^ sb;
    assign a_nan  = (ea == 8'hFF) && (ma != '0);
    assign b_nan  = (eb == 8'hFF) && (mb != '0);
    assign a_inf  = (ea == 8'hFF) && (ma == '0);
    assign b_inf  = (eb == 8'hFF) && (mb == '0);
    assign a_zero = (ea == 8'h00);             // denormals count as zero
    assign b_zero = (eb == 8'h00);

    // ---------------- add/sub datapath ----------------
    // Working mantissa format (27 bits): {hidden, 23 frac, guard, round, sticky}.
    logic               a_big, eff_sub;
    logic [7:0]         big_e, small_e, exp_diff;
    logic [23:0]        big_m, small_m;
    logic [53:0]        small_wide;
    logic [26:0]        small_al;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        add_n;
    logic signed [9:0]  add_e;
    logic               add_s;

    always_comb begin
        a_big    = {ea, ma} >= {eb, mb};
        big_e    = a_big ? ea : eb;
        small_e  = a_big ? eb : ea;
        big_m    = a_big ? {1'b1, ma} : {1'b1, mb};
        small_m  = a_big ? {1'b1, mb} : {1'b1, ma};
        add_s    = a_big ? sa : sb_add;
        exp_diff = big_e - small_e;
        // Shifted-out bits land in the low half and fold into sticky.
        small_wide = {small_m, 3'b000, 27'b0} >> exp_diff;
        if (exp_diff >= 8'd26)
            small_al = 27'd1;
        else
            small_al = small_wide[53:27] | {26'b0, |small_wide[26:0]};
        eff_sub = sa ^ sb_add;
        if (eff_sub)
            sum = {1'b0, big_m, 3'b000} - {1'b0, small_al};
        else
            sum = {1'b0, big_m, 3'b000} + {1'b0, small_al};
        // Leading-zero count over bits 26..0; the highest set bit wins.
        lz = '0;
        for (int i = 0; i <= 26; i++)
            if (sum[i]) lz = 5'(26 - i);
        add_e = $signed({2'b00, big_e});
        add_n = sum[26:0] << lz;
        if (!eff_sub && sum[27]) begin
            add_n = {sum[27:2], sum[1] | sum[0]};
            add_e = add_e + 10'sd1;
        end else begin
            add_e = add_e - $signed({5'b0, lz});
        end
        // Exact cancellation: a zero mantissa reaches the rounder, forced to +0.
        if (sum == '0)
            add_s = 1'b0;
    end

    // ---------------- multiply datapath ----------------
    logic [47:0]        prod;
    logic [26:0]        mul_n;
    logic signed [9:0]  mul_e;

    always_comb begin
        prod  = {24'b0, 1'b1, ma} * {24'b0, 1'b1, mb};
        mul_e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            mul_n = {prod[47:24], prod[23], prod[22], |prod[21:0]};
            mul_e = mul_e + 10'sd1;
        end else begin
            mul_n = {prod[46:23], prod[22], prod[21], |prod[20:0]};
        end
    end

    // ---------------- shared round-to-nearest-even and pack ----------------
    logic [26:0]        rn;
    logic signed [9:0]  re, re_fin;
    logic               rs, rup, rcarry;
    logic [22:0]        rfrac;
    logic [31:0]        rounded;

    always_comb begin
        rn  = (fopcode == 3'd2) ? mul_n : add_n;
        re  = (fopcode == 3'd2) ? mul_e : add_e;
        rs  = (fopcode == 3'd2) ? sm    : add_s;
        rup = rn[2] & (rn[1] | rn[0] | rn[3]);
        // Fraction carry-out means the mantissa reached 2.0: fraction is 0, exp+1.
        {rcarry, rfrac} = {1'b0, rn[25:3]} + {23'b0, rup};
        re_fin = re + $signed({9'b0, rcarry});
        if (!rn[26])
            rounded = {rs, 31'b0};
        else if (re_fin >= 10'sd255)
            rounded = {rs, 8'hFF, 23'b0};
        else if (re_fin <= 10'sd0)
            rounded = {rs, 31'b0};
        else
            rounded = {rs, re_fin[7:0], rfrac};
    end

    // ---------------- FP special-case selection ----------------
    logic [31:0] fp_res;

    always_comb begin
        fp_res = '0;
        case (fopcode)
            3'd0, 3'd1: begin
                if (a_nan || b_nan)       fp_res = QNAN;
                else if (a_inf && b_inf)  fp_res = (sa != sb_add) ? QNAN : {sa, 8'hFF, 23'b0};
                else if (a_inf)           fp_res = {sa, 8'hFF, 23'b0};
                else if (b_inf)           fp_res = {sb_add, 8'hFF, 23'b0};
                else if (a_zero && b_zero) fp_res = {sa & sb_add, 31'b0};
                else if (a_zero)          fp_res = {sb_add, fop_b[30:0]};
                else if (b_zero)          fp_res = fop_a;
                else                      fp_res = rounded;
            end
            3'd2: begin
                if (a_nan || b_nan)                          fp_res = QNAN;
                else if ((a_inf && b_zero) || (a_zero && b_inf)) fp_res = QNAN;
                else if (a_inf || b_inf)                     fp_res = {sm, 8'hFF, 23'b0};
                else if (a_zero || b_zero)                   fp_res = {sm, 31'b0};
                else                                         fp_res = rounded;
            end
            default: fp_res = '0;
        endcase
    end

    // ---------------- output registers ----------------
    logic [63:0] result_d, result_q;
    logic [31:0] fresult_d, fresult_q;

    always_comb begin
        result_d  = valid ? int_res : result_q;
        fresult_d = valid ? fp_res  : fresult_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            fresult_q <= '0;
        end else begin
            result_q  <= result_d;
            fresult_q <= fresult_d;
        end
    end

    assign result  = result_q;
    assign fresult = fresult_q;

endmodule

// File: tb/tb_alu64_fpu_unit.sv
// Bench for alu64_fpu_unit: directed vector table, hand sequences for reset
// and hold, then randomized traffic against a reference model that does the
// FP arithmetic in double precision and rounds to binary32 by value.
module tb_alu64_fpu_unit;
    logic        clk, rst, valid;
    logic [63:0] op_a, op_b, result;
    logic [3:0]  opcode;
    logic [31:0] fop_a, fop_b, fresult;
    logic [2:0]  fopcode;

    int errors = 0;
    int checks = 0;

    alu64_fpu_unit dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .valid(valid), .result(result), .fop_a(fop_a), .fop_b(fop_b),
        .fopcode(fopcode), .fresult(fresult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a, b;
        logic [2:0]  fop;
        logic [31:0] fa, fb;
        logic [63:0] er;
        logic [31:0] ef;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] int_model(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[5:0];
            4'h6: return a >> b[5:0];
            4'h7: return $signed(a) >>> b[5:0];
            4'h8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'h9: return (a < b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    // binary32 -> real; denormals become signed zero
    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'hFF)
            d = (f[22:0] != 0) ? 64'h7FF8_0000_0000_0000 : {f[31], 11'h7FF, 52'b0};
        else if (f[30:23] == 8'h00)
            d = {f[31], 63'b0};
        else
            d = {f[31], 11'({3'b0, f[30:23]}) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // real -> binary32, nearest-even, overflow to inf, tiny results flush
    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        int          e;
        logic [52:0] m;
        logic [24:0] k;
        logic [28:0] rem;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'b0};
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        e   = int'(d[62:52]) - 896;
        m   = {1'b1, d[51:0]};
        k   = {1'b0, m[52:29]};
        rem = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && k[0])) k = k + 25'd1;
        if (k[24]) begin
            k = k >> 1;
            e = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        if (e <= 0)   return {d[63], 31'b0};
        return {d[63], 8'(e), k[22:0]};
    endfunction

    function automatic logic [31:0] fp_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd0: return r2f(f2r(a) + f2r(b));
            3'd1: return r2f(f2r(a) + f2r({~b[31], b[30:0]}));
            3'd2: return r2f(f2r(a) * f2r(b));
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] specials [7] = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                      32'h7FC0_0000, 32'h0000_0123, 32'h3F80_0000};
        int pick;
        logic [31:0] f;
        pick = int'($urandom_range(0, 9));
        f = $urandom;
        if (pick == 0)
            f = specials[$urandom_range(0, 6)];
        else if (pick <= 6)
            f[30:23] = 8'($urandom_range(100, 154));
        return f;
    endfunction

    vec_t        tbl [16];
    logic [63:0] exp_r;
    logic [31:0] exp_f;

    initial begin
        tbl[0]  = '{4'h0, 64'd5, 64'd3, 3'd0, 32'h4040_0000, 32'h4000_0000, 64'd8, 32'h40A0_0000};
        tbl[1]  = '{4'h1, 64'd5, 64'd3, 3'd1, 32'h3F80_0000, 32'h3F80_0000, 64'd2, 32'h0000_0000};
        tbl[2]  = '{4'h7, 64'h8000_0000_0000_0000, 64'd63, 3'd2, 32'h7F00_0000, 32'h4000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 32'h7F80_0000};
        tbl[3]  = '{4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 32'h7F80_0001, 32'h3F80_0000, 64'd1, 32'h7FC0_0000};
        tbl[4]  = '{4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 32'h7F80_0000, 32'hFF80_0000, 64'd0, 32'h7FC0_0000};
        tbl[5]  = '{4'hF, 64'h1234, 64'h5678, 3'd2, 32'h0000_0000, 32'h7F80_0000, 64'd0, 32'h7FC0_0000};
        tbl[6]  = '{4'h5, 64'd1, 64'h44, 3'd5, 32'h3F80_0000, 32'h3F80_0000, 64'h10, 32'h0000_0000};
        tbl[7]  = '{4'h6, 64'h8000_0000_0000_0000, 64'd63, 3'd0, 32'h8000_0000, 32'h8000_0000, 64'd1, 32'h8000_0000};
        tbl[8]  = '{4'h4, 64'hF0F0, 64'hFF00, 3'd2, 32'h8000_0001, 32'h3F80_0000, 64'h0FF0, 32'h8000_0000};
        tbl[9]  = '{4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 32'h3F80_0000, 32'h3380_0000, 64'd0, 32'h3F80_0000};
        tbl[10] = '{4'h3, 64'hF0F0, 64'h0F0F, 3'd0, 32'h3F80_0000, 32'h3440_0000, 64'hFFFF, 32'h3F80_0002};
        tbl[11] = '{4'h2, 64'hF0F0, 64'hFF00, 3'd1, 32'h3F80_0001, 32'h3F80_0000, 64'hF000, 32'h3400_0000};
        tbl[12] = '{4'h1, 64'd0, 64'd1, 3'd2, 32'h3FC0_0000, 32'h3FC0_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4010_0000};
        tbl[13] = '{4'h0, 64'd0, 64'd0, 3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 64'd0, 32'h7F80_0000};
        tbl[14] = '{4'hA, 64'd1, 64'd1, 3'd2, 32'h8080_0000, 32'h0080_0000, 64'd0, 32'h8000_0000};
        tbl[15] = '{4'h7, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 3'd1, 32'h3F80_0000, 32'hBF80_0000,
                    64'hFFFF_FFFF_FFFF_FFFC, 32'h4000_0000};

        // reset for 3 cycles, then idle
        rst = 1'b1; valid = 1'b0; opcode = '0; fopcode = '0;
        op_a = 64'd77; op_b = 64'd9; fop_a = 32'h3F80_0000; fop_b = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset fresult", {32'b0, fresult}, 64'd0);

        // directed table, issued back to back
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            opcode = tbl[i].op; op_a = tbl[i].a; op_b = tbl[i].b;
            fopcode = tbl[i].fop; fop_a = tbl[i].fa; fop_b = tbl[i].fb;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d result", i), result, tbl[i].er);
            chk($sformatf("vec%0d fresult", i), {32'b0, fresult}, {32'b0, tbl[i].ef});
        end
        exp_r = tbl[15].er;
        exp_f = tbl[15].ef;

        // valid=0: outputs hold while inputs change
        valid = 1'b0;
        opcode = 4'h0; op_a = 64'd100; op_b = 64'd200;
        fopcode = 3'd0; fop_a = 32'h4040_0000; fop_b = 32'h4040_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("hold result", result, exp_r);
        chk("hold fresult", {32'b0, fresult}, {32'b0, exp_f});

        // reset beats valid
        rst = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst over valid result", result, 64'd0);
        chk("rst over valid fresult", {32'b0, fresult}, 64'd0);
        rst = 1'b0;
        exp_r = '0;
        exp_f = '0;

        // randomized traffic with occasional idle cycles
        for (int n = 0; n < 800; n++) begin
            valid   = ($urandom_range(0, 7) != 0);
            opcode  = 4'($urandom_range(0, 15));
            op_a    = {$urandom, $urandom};
            op_b    = {$urandom, $urandom};
            fopcode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            fop_a   = rnd_fp();
            fop_b   = rnd_fp();
            if ($urandom_range(0, 3) == 0) begin
                // near-cancellation / equal-exponent operands
                fop_b = fop_a;
                if ($urandom_range(0, 1) == 0) fop_b[31] = ~fop_a[31];
                fop_b[7:0] = 8'($urandom);
            end
            if (valid) begin
                exp_r = int_model(opcode, op_a, op_b);
                exp_f = fp_model(fopcode, fop_a, fop_b);
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d op%0h result a=%h b=%h", n, opcode, op_a, op_b), result, exp_r);
            chk($sformatf("rnd%0d fop%0d fresult a=%h b=%h", n, fopcode, fop_a, fop_b),
                {32'b0, fresult}, {32'b0, exp_f});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
